// File: rtl/switch_debouncer.sv
// Input conditioning for the LED blinker: two-flop synchroniser plus an independent
// debounce counter per switch channel, producing clean levels and one-cycle edge pulses.
module switch_debouncer #(
  parameter int NUM_SW         = 3,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CNT_W          = 18
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [NUM_SW-1:0] i_sw_raw,
  output logic [NUM_SW-1:0] o_sw_clean,
  output logic [NUM_SW-1:0] o_sw_rise,
  output logic [NUM_SW-1:0] o_sw_fall
);

  typedef enum logic [1:0] {
    ST_STABLE   = 2'd0,
    ST_COUNTING = 2'd1,
    ST_ACCEPT   = 2'd2
  } chan_state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_SW-1:0] sync1_q;
  logic [NUM_SW-1:0] sync2_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_sw_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
    // chan_state is the per-channel decode of the current cycle, kept visible for checkers.
    chan_state_e      chan_state;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    always_comb begin
      chan_state = ST_STABLE;
      cnt_d      = '0;
      clean_d    = clean_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      if (sync2_q[g] != clean_q) begin
        if (cnt_q == LAST_CNT) begin
          chan_state = ST_ACCEPT;
          clean_d    = sync2_q[g];
          rise_d     = sync2_q[g];
          fall_d     = ~sync2_q[g];
        end else begin
          chan_state = ST_COUNTING;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        cnt_q   <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign o_sw_clean[g] = clean_q;
    assign o_sw_rise[g]  = rise_q;
    assign o_sw_fall[g]  = fall_q;
  end

endmodule
